// File: rtl/wwm_pkg.sv
// Shared definitions for the input controller: debounce state encoding,
// default debounce width and button index constants.
package wwm_pkg;

  localparam int DEB_BITS_DEF = 20;

  localparam int BTN_U = 0;
  localparam int BTN_R = 1;
  localparam int BTN_C = 2;
  localparam int N_BTN = 3;

  typedef enum logic [2:0] {
    DB_IDLE    = 3'd0,
    DB_W_PRESS = 3'd1,
    DB_PULSE   = 3'd2,
    DB_HELD    = 3'd3,
    DB_W_REL   = 3'd4
  } deb_state_e;

endpackage

// File: rtl/wwm_debouncer.sv
// One button channel: 2-flop synchronizer, saturating wait counter and a
// press/release FSM that yields a one-cycle press pulse and a debounced level.
module wwm_debouncer
  import wwm_pkg::*;
#(
  parameter int DEB_BITS = DEB_BITS_DEF
) (
  input  logic clk,
  input  logic Reset_n,
  input  logic raw_i,
  output logic pulse_o,
  output logic db_o
);

  logic                sync1_q;
  logic                sync2_q;
  deb_state_e          state_q;
  deb_state_e          state_d;
  logic [DEB_BITS-1:0] cnt_q;
  logic [DEB_BITS-1:0] cnt_d;
  logic                pulse_q;
  logic                pulse_d;
  logic                db_q;
  logic                db_d;
  logic                cnt_full_s;

  assign cnt_full_s = &cnt_q;

  // Synchronizer, FSM, counter and output flops.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= DB_IDLE;
      cnt_q   <= {DEB_BITS{1'b0}};
      pulse_q <= 1'b0;
      db_q    <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      db_q    <= db_d;
    end
  end

  // Next-state, counter and output decode; outputs follow the next state so
  // they are registered alongside it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DB_IDLE: begin
        if (sync2_q) begin
          state_d = DB_W_PRESS;
          cnt_d   = {DEB_BITS{1'b0}};
        end else begin
          state_d = DB_IDLE;
        end
      end
      DB_W_PRESS: begin
        if (!sync2_q) begin
          state_d = DB_IDLE;
        end else if (cnt_full_s) begin
          state_d = DB_PULSE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DB_PULSE: begin
        state_d = DB_HELD;
      end
      DB_HELD: begin
        if (!sync2_q) begin
          state_d = DB_W_REL;
          cnt_d   = {DEB_BITS{1'b0}};
        end else begin
          state_d = DB_HELD;
        end
      end
      DB_W_REL: begin
        if (sync2_q) begin
          state_d = DB_HELD;
        end else if (cnt_full_s) begin
          state_d = DB_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = DB_IDLE;
        cnt_d   = {DEB_BITS{1'b0}};
      end
    endcase
    pulse_d = (state_d == DB_PULSE);
    db_d    = (state_d == DB_PULSE) || (state_d == DB_HELD) || (state_d == DB_W_REL);
  end

  assign pulse_o = pulse_q;
  assign db_o    = db_q;

endmodule

// File: rtl/wwm_input_ctrl.sv
// Board input front end: three debounced buttons with press pulses and
// synchronized switch velocities that freeze while lock is high.
module wwm_input_ctrl
  import wwm_pkg::*;
#(
  parameter int DEB_BITS = DEB_BITS_DEF
) (
  input  logic       clk,
  input  logic       Reset_n,
  input  logic       BtnU,
  input  logic       BtnR,
  input  logic       BtnC,
  input  logic [7:0] Sw,
  input  logic       lock,
  output logic       Start_p,
  output logic       Fire_p,
  output logic       Clear_p,
  output logic [2:0] Btn_db,
  output logic [3:0] vX,
  output logic [3:0] vY
);

  logic [N_BTN-1:0] btn_raw_s;
  logic [N_BTN-1:0] pulse_s;
  logic [N_BTN-1:0] db_s;
  logic [7:0]       sw_s1_q;
  logic [7:0]       sw_s2_q;
  logic [7:0]       vel_q;
  logic [7:0]       vel_d;

  assign btn_raw_s[BTN_U] = BtnU;
  assign btn_raw_s[BTN_R] = BtnR;
  assign btn_raw_s[BTN_C] = BtnC;

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    wwm_debouncer #(.DEB_BITS(DEB_BITS)) u_deb (
      .clk     (clk),
      .Reset_n (Reset_n),
      .raw_i   (btn_raw_s[g]),
      .pulse_o (pulse_s[g]),
      .db_o    (db_s[g])
    );
  end

  // Switch synchronizer and velocity capture register.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sw_s1_q <= 8'h00;
      sw_s2_q <= 8'h00;
      vel_q   <= 8'h00;
    end else begin
      sw_s1_q <= Sw;
      sw_s2_q <= sw_s1_q;
      vel_q   <= vel_d;
    end
  end

  // Velocity follows the switches unless frozen by lock.
  always_comb begin
    if (lock) begin
      vel_d = vel_q;
    end else begin
      vel_d = sw_s2_q;
    end
  end

  assign Start_p = pulse_s[BTN_U];
  assign Fire_p  = pulse_s[BTN_R];
  assign Clear_p = pulse_s[BTN_C];
  assign Btn_db  = db_s;
  assign vX      = vel_q[7:4];
  assign vY      = vel_q[3:0];

endmodule

// File: tb/tb_wwm_input_ctrl.sv
// Directed bench for wwm_input_ctrl with DEB_BITS=3 (press/release latency 11 edges).
module tb_wwm_input_ctrl;

  localparam int DB = 3;

  logic       clk = 1'b0;
  logic       Reset_n;
  logic       BtnU;
  logic       BtnR;
  logic       BtnC;
  logic [7:0] Sw;
  logic       lock;
  logic       Start_p;
  logic       Fire_p;
  logic       Clear_p;
  logic [2:0] Btn_db;
  logic [3:0] vX;
  logic [3:0] vY;

  int n_total = 0;
  int n_bad   = 0;

  int su_cnt, su_edge, fi_cnt, fi_edge, cl_cnt;
  int rise_e, fall_e;
  logic db_seen, db_min;

  wwm_input_ctrl #(.DEB_BITS(DB)) dut (
    .clk     (clk),
    .Reset_n (Reset_n),
    .BtnU    (BtnU),
    .BtnR    (BtnR),
    .BtnC    (BtnC),
    .Sw      (Sw),
    .lock    (lock),
    .Start_p (Start_p),
    .Fire_p  (Fire_p),
    .Clear_p (Clear_p),
    .Btn_db  (Btn_db),
    .vX      (vX),
    .vY      (vY)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    Reset_n = 1'b0;
    BtnU = 1'b0; BtnR = 1'b0; BtnC = 1'b0;
    Sw = 8'h00; lock = 1'b0;
    repeat (3) cyc();
    chk_eq("rst_outs", {29'd0, Start_p, Fire_p, Clear_p}, 32'd0);
    chk_eq("rst_db", {29'd0, Btn_db}, 32'd0);
    chk_eq("rst_vel", {24'd0, vX, vY}, 32'd0);
    @(negedge clk);
    Reset_n = 1'b1;
    repeat (2) cyc();

    // clean press on BtnU, 40 cycles, then release
    BtnU = 1'b1; su_cnt = 0; su_edge = 0; rise_e = 0;
    for (int e = 1; e <= 40; e++) begin
      cyc();
      if (Start_p) begin su_cnt++; su_edge = e; end
      if (Btn_db[0] && rise_e == 0) rise_e = e;
    end
    chk_eq("press_pulse_cnt", su_cnt, 1);
    chk_eq("press_pulse_edge", su_edge, 11);
    chk_eq("press_db_rise", rise_e, 11);
    chk_eq("press_db_held", {31'd0, Btn_db[0]}, 32'd1);
    BtnU = 1'b0; fall_e = 0;
    for (int e = 1; e <= 20; e++) begin
      cyc();
      if (Start_p) su_cnt++;
      if (!Btn_db[0] && fall_e == 0) fall_e = e;
    end
    chk_eq("release_db_fall", fall_e, 11);
    chk_eq("release_no_pulse", su_cnt, 1);

    // 5-cycle glitch on BtnR
    fi_cnt = 0; db_seen = 1'b0;
    BtnR = 1'b1;
    for (int e = 1; e <= 25; e++) begin
      if (e == 6) BtnR = 1'b0;
      cyc();
      if (Fire_p) fi_cnt++;
      if (Btn_db[1]) db_seen = 1'b1;
    end
    chk_eq("glitch_fire", fi_cnt, 0);
    chk_eq("glitch_db", {31'd0, db_seen}, 32'd0);

    // BtnC press, then release bounce returning high
    cl_cnt = 0; db_min = 1'b1;
    BtnC = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      cyc();
      if (Clear_p) cl_cnt++;
    end
    chk_eq("bounce_db_pre", {31'd0, Btn_db[2]}, 32'd1);
    for (int e = 0; e < 18; e++) begin
      if (e < 8) BtnC = logic'((e >> 1) & 1);
      else BtnC = 1'b1;
      cyc();
      if (Clear_p) cl_cnt++;
      if (!Btn_db[2]) db_min = 1'b0;
    end
    chk_eq("bounce_db_stays", {31'd0, db_min}, 32'd1);
    BtnC = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      cyc();
      if (Clear_p) cl_cnt++;
    end
    chk_eq("bounce_clear_cnt", cl_cnt, 1);
    chk_eq("bounce_db_final", {31'd0, Btn_db[2]}, 32'd0);

    // velocity capture and lock
    Sw = 8'hA5;
    cyc(); cyc();
    chk_eq("vel_lat2", {24'd0, vX, vY}, 32'h00);
    cyc();
    chk_eq("vel_lat3", {24'd0, vX, vY}, 32'hA5);
    lock = 1'b1; Sw = 8'h3C;
    repeat (6) cyc();
    chk_eq("vel_locked", {24'd0, vX, vY}, 32'hA5);
    lock = 1'b0;
    repeat (3) cyc();
    chk_eq("vel_unlocked", {24'd0, vX, vY}, 32'h3C);

    // reset while BtnU is in W_PRESS
    BtnC = 1'b1;
    repeat (15) cyc();
    BtnU = 1'b1;
    repeat (5) cyc();
    chk_eq("pre_rst_state", {25'd0, Btn_db, vX}, {25'd0, 3'b100, 4'h3});
    #2;
    Reset_n = 1'b0;
    #1;
    chk_eq("async_rst_pulses", {29'd0, Start_p, Fire_p, Clear_p}, 32'd0);
    chk_eq("async_rst_db_vel", {21'd0, Btn_db, vX, vY}, 32'd0);
    BtnC = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    Reset_n = 1'b1;
    su_cnt = 0; su_edge = 0;
    for (int e = 1; e <= 15; e++) begin
      cyc();
      if (Start_p) begin su_cnt++; su_edge = e; end
    end
    chk_eq("post_rst_cnt", su_cnt, 1);
    chk_eq("post_rst_edge", su_edge, 11);

    // simultaneous press of BtnU and BtnR
    BtnU = 1'b0;
    repeat (20) cyc();
    BtnU = 1'b1; BtnR = 1'b1;
    su_cnt = 0; su_edge = 0; fi_cnt = 0; fi_edge = 0;
    for (int e = 1; e <= 15; e++) begin
      cyc();
      if (Start_p) begin su_cnt++; su_edge = e; end
      if (Fire_p) begin fi_cnt++; fi_edge = e; end
    end
    chk_eq("simul_start_edge", su_edge, 11);
    chk_eq("simul_fire_edge", fi_edge, 11);
    chk_eq("simul_counts", {su_cnt[15:0], fi_cnt[15:0]}, {16'd1, 16'd1});
    chk_eq("simul_db", {29'd0, Btn_db}, 32'd3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/wwm_input_ctrl.md
WWM_INPUT_CTRL -- requirements
Module: wwm_input_ctrl

Interface
REQ-001 The block SHALL have one parameter: DEB_BITS, default 20, debounce counter width; stable time is 2^DEB_BITS cycles, about 10.5 ms at 100 MHz.
REQ-002 The block SHALL have the following ports, with clock and reset first:
- clk  in  1  board clock; one clock domain; all flops on rising edge.
- Reset_n  in  1  reset, asynchronous, active-low.
- BtnU  in  1  raw Start button, asynchronous.
- BtnR  in  1  raw Fire button, asynchronous.
- BtnC  in  1  raw Clear button, asynchronous.
- Sw  in  8  raw switches, asynchronous; [7:4] x-velocity, [3:0] y-velocity.
- lock  in  1  velocity freeze; driven by state machine q_Animate.
- Start_p  out  1  single-cycle pulse per debounced BtnU press.
- Fire_p  out  1  single-cycle pulse per debounced BtnR press.
- Clear_p  out  1  single-cycle pulse per debounced BtnC press.
- Btn_db  out  3  debounced levels {C,R,U}.
- vX  out  4  captured x-velocity.
- vY  out  4  captured y-velocity.

Function
REQ-003 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-004 Each button SHALL have an independent debounce FSM with states IDLE, W_PRESS, PULSE, HELD, W_REL.
REQ-005 IDLE: db=0; on btn_s=1 go to W_PRESS and clear the counter.
REQ-006 W_PRESS: db=0.
- btn_s=0: go to IDLE.
- counter all-ones with btn_s=1: go to PULSE.
- otherwise: increment the counter.
REQ-007 PULSE: db=1 and the pulse output is 1 for exactly one cycle; then go unconditionally to HELD.
REQ-008 HELD: db=1; on btn_s=0 go to W_REL and clear the counter.
REQ-009 W_REL: db=1.
- btn_s=1: go to HELD (no new pulse).
- counter all-ones with btn_s=0: go to IDLE.
- otherwise: increment the counter.
REQ-010 Press latency: if raw is stable high, the pulse SHALL be high for the cycle after edge 2^DEB_BITS+3, counted from the first edge that samples raw high. Release SHALL drop db after the same count.
REQ-011 The debounce counter SHALL be DEB_BITS wide and SHALL NOT wrap; all-ones ends the wait.
REQ-012 Each press SHALL produce exactly one pulse, however long it is held; there is no auto-repeat.
REQ-013 The three buttons SHALL be fully independent; simultaneous presses SHALL give coincident pulses.
REQ-014 On each edge with lock=0, vX SHALL load synchronized Sw[7:4] and vY SHALL load Sw[3:0] (3-edge latency from raw).
REQ-015 While lock=1, vX and vY SHALL hold their values.
REQ-016 All outputs SHALL be registered; there are no combinational paths from inputs to outputs.

Reset
REQ-017 Reset_n=0 SHALL asynchronously force the following:
- all synchronizer flops to 0;
- all FSMs to IDLE and all counters to 0;
- Start_p, Fire_p, Clear_p, Btn_db, vX and vY to 0.
REQ-018 Reset asserted mid-operation SHALL abandon any pending pulse.
REQ-019 After reset release, a button held through reset SHALL be treated as a new press and pulse after the full REQ-010 latency.

Structure
REQ-020 Shared package wwm_pkg SHALL hold the following:
- debounce state encoding;
- DEB_BITS default;
- button index constants BTN_U=0, BTN_R=1, BTN_C=2.
REQ-021 Sub-module wwm_debouncer SHALL contain one synchronizer, one FSM and one counter; it SHALL be instantiated three times.
REQ-022 Switch synchronizing and velocity capture SHALL reside in wwm_input_ctrl itself.

Verification (DEB_BITS=3)
REQ-023 Glitch: BtnR high for 5 cycles, then low -> Fire_p never asserts and Btn_db[1] stays 0.
REQ-024 Clean press: BtnU high for 40 cycles.
- Start_p is high for one cycle only, after edge 11.
- Btn_db[0] is high from edge 11 until 11 edges after release.
REQ-025 Release bounce: BtnC toggled every 2 cycles for 6 cycles after a valid press -> exactly one Clear_p in total and Btn_db[2] stays 1 throughout.
REQ-026 Velocity lock: Sw=8'hA5 with lock=0 -> vX=4'hA and vY=4'h5 by edge 3. Then:
- lock=1, Sw=8'h3C -> vX/vY stay A/5;
- lock=0 -> vX/vY become 3/C within 3 edges.
REQ-027 Reset mid W_PRESS: assert Reset_n=0 while BtnU is held.
- All outputs go to 0 immediately.
- After release with BtnU still high, Start_p pulses 11 edges later.
REQ-028 Simultaneous press: BtnU and BtnR rise on the same edge -> Start_p and Fire_p assert in the same cycle.
